// File: rtl/stochastic_pkg.sv
// stochastic_pkg: FSM states, LFSR taps/seeds and shift helpers shared by the stochastic processor array
package stochastic_pkg;

    typedef enum logic [2:0] {S_IDLE, S_ENC, S_STREAM, S_DEC, S_DONE} state_t;

    localparam logic [15:0] R_SEED = 16'h0001;
    localparam logic [15:0] S_SEED = 16'hACE1;

    function automatic logic [15:0] r_taps(input int w);
        case (w)
            3:       return 16'h0006;
            4:       return 16'h000C;
            5:       return 16'h0014;
            6:       return 16'h0030;
            7:       return 16'h0060;
            8:       return 16'h00B8;
            9:       return 16'h0110;
            10:      return 16'h0240;
            11:      return 16'h0500;
            12:      return 16'h0829;
            13:      return 16'h100D;
            14:      return 16'h2015;
            15:      return 16'h6000;
            default: return 16'hD008;
        endcase
    endfunction

    // reciprocal polynomials of r_taps, so the select stream is decorrelated from the threshold stream
    function automatic logic [15:0] s_taps(input int w);
        case (w)
            3:       return 16'h0005;
            4:       return 16'h0009;
            5:       return 16'h0012;
            6:       return 16'h0021;
            7:       return 16'h0041;
            8:       return 16'h008E;
            9:       return 16'h0108;
            10:      return 16'h0204;
            11:      return 16'h0402;
            12:      return 16'h0CA0;
            13:      return 16'h1B00;
            14:      return 16'h3500;
            15:      return 16'h4001;
            default: return 16'h8805;
        endcase
    endfunction

    function automatic int enc_shift(input int q_w, input int d_w);
        return q_w - d_w;
    endfunction

    function automatic int stoch_shift(input int q_w, input int l, input int n);
        return q_w - l + $clog2(n);
    endfunction

endpackage

// File: rtl/stochastic_mux_adder.sv
// stochastic_mux_adder: per-operand stream generators, random operand select and two ones counters
module stochastic_mux_adder
    import stochastic_pkg::*;
#(
    parameter int N_OPS = 2,
    parameter int Q_W   = 10,
    parameter int L     = 10
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               en,
    input  logic [N_OPS*Q_W-1:0] a_vec,
    input  logic [N_OPS*Q_W-1:0] b_vec,
    output logic [L:0]         cnt_a,
    output logic [L:0]         cnt_b
);

    localparam int LG = $clog2(N_OPS);
    localparam logic [L-1:0] RT = L'(r_taps(L));
    localparam logic [L-1:0] ST = L'(s_taps(L));
    localparam logic [L-1:0] RS = L'(R_SEED);
    localparam logic [L-1:0] SS = L'(S_SEED);

    logic [L-1:0]     r, s;
    logic [N_OPS-1:0] bit_a, bit_b;
    logic [LG-1:0]    sel;

    always_comb begin
        bit_a = '0;
        bit_b = '0;
        for (int i = 0; i < N_OPS; i++) begin
            bit_a[i] = a_vec[i*Q_W + Q_W-1 -: L] > r;
            bit_b[i] = b_vec[i*Q_W + Q_W-1 -: L] > r;
        end
    end

    assign sel = s[LG-1:0];

    always_ff @(posedge clk) begin
        if (rst || load) begin
            r     <= RS;
            s     <= SS;
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (en) begin
            r     <= {r[L-2:0], ^(r & RT)};
            s     <= {s[L-2:0], ^(s & ST)};
            cnt_a <= cnt_a + {{L{1'b0}}, bit_a[sel]};
            cnt_b <= cnt_b + {{L{1'b0}}, bit_b[sel]};
        end
    end

endmodule

// File: rtl/stochastic_processor_array.sv
// stochastic_processor_array: encrypts operands, sums ciphertexts exactly or by stochastic MUX add, decrypts
module stochastic_processor_array
    import stochastic_pkg::*;
#(
    parameter int N_OPS  = 2,
    parameter int DATA_W = 8,
    parameter int Q_W    = 10,
    parameter int L      = 10,
    parameter logic [Q_W-1:0] SK = Q_W'(3)
)(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [N_OPS*DATA_W-1:0] bytes_in,
    input  logic [N_OPS*Q_W-1:0]    pk_in,
    output logic [2*Q_W-1:0]        ct_sum,
    output logic [DATA_W-1:0]       res,
    output logic                    busy,
    output logic                    done
);

    localparam int DS = enc_shift(Q_W, DATA_W);
    localparam int SS = stoch_shift(Q_W, L, N_OPS);
    localparam logic [Q_W-1:0] HALF = Q_W'(1) << (DS - 1);

    state_t                  state;
    logic                    mode_q;
    logic [N_OPS*DATA_W-1:0] m_q;
    logic [N_OPS*Q_W-1:0]    pk_q, a_r, b_r;
    logic [L-1:0]            step;
    logic [L:0]              cnt_a, cnt_b;
    logic [Q_W-1:0]          sum_a, sum_b, sa, sb, ca, cb, diff, rnd;
    logic [DATA_W-1:0]       res_n;

    stochastic_mux_adder #(.N_OPS(N_OPS), .Q_W(Q_W), .L(L)) u_mux (
        .clk   (clk),
        .rst   (rst),
        .load  (state == S_ENC),
        .en    (state == S_STREAM),
        .a_vec (a_r),
        .b_vec (b_r),
        .cnt_a (cnt_a),
        .cnt_b (cnt_b)
    );

    always_comb begin
        sum_a = '0;
        sum_b = '0;
        for (int i = 0; i < N_OPS; i++) begin
            sum_a = sum_a + a_r[i*Q_W +: Q_W];
            sum_b = sum_b + b_r[i*Q_W +: Q_W];
        end
        sa    = Q_W'(cnt_a) << SS;
        sb    = Q_W'(cnt_b) << SS;
        ca    = mode_q ? sa : sum_a;
        cb    = mode_q ? sb : sum_b;
        diff  = cb - ca * SK;
        rnd   = diff + HALF;
        res_n = rnd[Q_W-1 -: DATA_W];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            ct_sum <= '0;
            res    <= '0;
            mode_q <= 1'b0;
            step   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state  <= S_ENC;
                    mode_q <= mode;
                end
                S_ENC: begin
                    state <= mode_q ? S_STREAM : S_DEC;
                    step  <= '0;
                end
                S_STREAM: begin
                    step <= step + 1'b1;
                    if (&step) state <= S_DEC;
                end
                S_DEC: begin
                    state  <= S_DONE;
                    ct_sum <= {ca, cb};
                    res    <= res_n;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // operand and ciphertext registers need no reset: they are always written before use
    always_ff @(posedge clk) begin
        if (!rst && state == S_IDLE && start) begin
            m_q  <= bytes_in;
            pk_q <= pk_in;
        end
        if (state == S_ENC)
            for (int i = 0; i < N_OPS; i++) begin
                a_r[i*Q_W +: Q_W] <= pk_q[i*Q_W +: Q_W];
                b_r[i*Q_W +: Q_W] <= pk_q[i*Q_W +: Q_W] * SK + {m_q[i*DATA_W +: DATA_W], {DS{1'b0}}};
            end
    end

    assign busy = state != S_IDLE;
    assign done = state == S_DONE;

endmodule

// File: tb/tb_stochastic_processor_array.sv
// tb_stochastic_processor_array: directed-vector bench for the stochastic processor array
module tb_stochastic_processor_array;

    typedef struct {
        logic [7:0] m0, m1;
        logic [9:0] p0, p1, ea, eb;
        logic [7:0] er;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, mode = 1'b0, start4 = 1'b0, mode4 = 1'b0;
    logic [15:0] bytes_in = '0;
    logic [19:0] pk_in = '0;
    logic [31:0] bytes4 = '0;
    logic [39:0] pk4 = '0;
    logic [19:0] ct_sum, ct4;
    logic [7:0]  res, res4;
    logic        busy, done, busy4, done4;
    int          n_vec = 0, n_err = 0;
    vec_t        tbl[6];

    always #5 clk = ~clk;

    stochastic_processor_array dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bytes_in(bytes_in), .pk_in(pk_in),
        .ct_sum(ct_sum), .res(res), .busy(busy), .done(done)
    );

    stochastic_processor_array #(.N_OPS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .bytes_in(bytes4), .pk_in(pk4),
        .ct_sum(ct4), .res(res4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int cdist(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] d;
        d = a - b;
        return (d > 10'd512) ? 1024 - int'(d) : int'(d);
    endfunction

    task automatic chk_near(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_vec++;
        if (cdist(act, exp) > 48) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d +/-48", name, act, exp);
        end
    endtask

    // start is held for the cycle after an edge; lat counts edges until done is seen
    task automatic run(input logic md, input logic [7:0] m0, input logic [7:0] m1,
                       input logic [9:0] p0, input logic [9:0] p1, output int lat);
        @(posedge clk); #1;
        start = 1'b1; mode = md; bytes_in = {m1, m0}; pk_in = {p1, p0};
        lat = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end while (!done && lat < 2000);
    endtask

    initial begin
        int lat;
        logic [19:0] ct_first;
        logic [7:0]  res_first;
        logic        seen;
        tbl[0] = '{8'd5,   8'd3,   10'd234,  10'd567,  10'd801,  10'd387,  8'd8};
        tbl[1] = '{8'd255, 8'd1,   10'd567,  10'd890,  10'd433,  10'd275,  8'd0};
        tbl[2] = '{8'd200, 8'd100, 10'd678,  10'd123,  10'd801,  10'd531,  8'd44};
        tbl[3] = '{8'd0,   8'd0,   10'd0,    10'd0,    10'd0,    10'd0,    8'd0};
        tbl[4] = '{8'd128, 8'd128, 10'd1023, 10'd1023, 10'd1022, 10'd1018, 8'd0};
        tbl[5] = '{8'd17,  8'd42,  10'd1,    10'd2,    10'd3,    10'd245,  8'd59};

        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_done", {31'd0, done}, 0);
        chk("reset_res", {24'd0, res}, 0);
        chk("reset_ct", {12'd0, ct_sum}, 0);
        chk("reset_busy4", {31'd0, busy4}, 0);
        start = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run(1'b0, tbl[i].m0, tbl[i].m1, tbl[i].p0, tbl[i].p1, lat);
            chk($sformatf("v%0d_latency", i), lat, 3);
            chk($sformatf("v%0d_ct_a", i), {22'd0, ct_sum[19:10]}, {22'd0, tbl[i].ea});
            chk($sformatf("v%0d_ct_b", i), {22'd0, ct_sum[9:0]}, {22'd0, tbl[i].eb});
            chk($sformatf("v%0d_res", i), {24'd0, res}, {24'd0, tbl[i].er});
        end
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done}, 0);
        chk("idle_not_busy", {31'd0, busy}, 0);
        chk("res_holds", {24'd0, res}, {24'd0, tbl[5].er});

        run(1'b1, 8'd50, 8'd75, 10'd456, 10'd789, lat);
        chk("stoch_latency", lat, 1027);
        chk_near("stoch_ct_a", ct_sum[19:10], 10'd221);
        chk_near("stoch_ct_b", ct_sum[9:0], 10'd139);
        ct_first = ct_sum;
        res_first = res;
        run(1'b1, 8'd50, 8'd75, 10'd456, 10'd789, lat);
        chk("stoch_repeat_latency", lat, 1027);
        chk("stoch_repeat_ct", {12'd0, ct_sum}, {12'd0, ct_first});
        chk("stoch_repeat_res", {24'd0, res}, {24'd0, res_first});

        // a second start mid-stream with other operands must not disturb the run
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; bytes_in = {8'd75, 8'd50}; pk_in = {10'd789, 10'd456};
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                bytes_in = {8'd9, 8'd200}; pk_in = {10'd17, 10'd999}; mode = 1'b0;
            end
            start = (lat == 11);
            if (lat == 12) chk("mid_stream_busy", {31'd0, busy}, 1);
        end while (!done && lat < 2000);
        start = 1'b0;
        chk("mid_start_latency", lat, 1027);
        chk("mid_start_ct", {12'd0, ct_sum}, {12'd0, ct_first});
        chk("mid_start_res", {24'd0, res}, {24'd0, res_first});

        // reset during STREAM
        @(posedge clk); #1;
        start = 1'b1; mode = 1'b1; bytes_in = {8'd75, 8'd50}; pk_in = {10'd789, 10'd456};
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("pre_rst_busy", {31'd0, busy}, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_busy", {31'd0, busy}, 0);
        chk("rst_mid_done", {31'd0, done}, 0);
        chk("rst_mid_res", {24'd0, res}, 0);
        chk("rst_mid_ct", {12'd0, ct_sum}, 0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (1100) begin
            @(posedge clk); #1;
            seen |= done;
        end
        chk("no_done_after_rst", {31'd0, seen}, 0);
        run(1'b0, tbl[0].m0, tbl[0].m1, tbl[0].p0, tbl[0].p1, lat);
        chk("post_rst_latency", lat, 3);
        chk("post_rst_ct", {12'd0, ct_sum}, {12'd0, tbl[0].ea, tbl[0].eb});
        chk("post_rst_res", {24'd0, res}, {24'd0, tbl[0].er});

        // start in the DONE cycle is dropped, start in the next IDLE cycle is taken
        start = 1'b1; mode = 1'b0; bytes_in = {tbl[2].m1, tbl[2].m0}; pk_in = {tbl[2].p1, tbl[2].p0};
        @(posedge clk); #1;
        chk("done_start_ignored", {31'd0, busy}, 0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (lat == 1) chk("idle_start_taken", {31'd0, busy}, 1);
        end while (!done && lat < 2000);
        chk("b2b_latency", lat, 3);
        chk("b2b_res", {24'd0, res}, {24'd0, tbl[2].er});
        chk("b2b_ct", {12'd0, ct_sum}, {12'd0, tbl[2].ea, tbl[2].eb});

        // four-operand instance
        @(posedge clk); #1;
        start4 = 1'b1; bytes4 = {8'd40, 8'd30, 8'd20, 8'd10}; pk4 = {10'd4, 10'd3, 10'd2, 10'd1};
        lat = 0;
        do begin
            @(posedge clk); #1;
            start4 = 1'b0;
            lat++;
        end while (!done4 && lat < 2000);
        chk("n4_latency", lat, 3);
        chk("n4_ct_a", {22'd0, ct4[19:10]}, 10);
        chk("n4_ct_b", {22'd0, ct4[9:0]}, 430);
        chk("n4_res", {24'd0, res4}, 100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
